// File: rtl/decoder_scan.sv
// One-hot decoder with a direct-select mode and a timed auto-scan mode.
// Every output is registered; a disabled edge blanks y but freezes scan position.
module decoder_scan #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] y,
    output logic [SEL_W-1:0]   idx,
    output logic               err,
    output logic               wrap
);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST     = SEL_W'(NUM_OUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    generate
        if (NUM_OUT < 2 || NUM_OUT > (1 << SEL_W)) begin : g_bad_num_out
            $error("decoder_scan: NUM_OUT must lie in 2..2**SEL_W");
        end
        if (DWELL < 1) begin : g_bad_dwell
            $error("decoder_scan: DWELL must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [SEL_W-1:0]   idx_nxt;
    logic [NUM_OUT-1:0] y_nxt;
    logic               err_nxt, wrap_nxt;

    always_comb begin
        cnt_nxt  = cnt;
        idx_nxt  = idx;
        y_nxt    = '0;
        err_nxt  = 1'b0;
        wrap_nxt = 1'b0;
        if (en) begin
            if (!mode) begin
                cnt_nxt = '0;
                if (32'(sel) < NUM_OUT) begin
                    idx_nxt = sel;
                    y_nxt   = NUM_OUT'(1) << sel;
                end else begin
                    err_nxt = 1'b1;
                end
            end else begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (idx == LAST) begin
                        idx_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + SEL_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                // y tracks the index being loaded, not the one being left
                y_nxt = NUM_OUT'(1) << idx_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            idx  <= '0;
            y    <= '0;
            err  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            idx  <= idx_nxt;
            y    <= y_nxt;
            err  <= err_nxt;
            wrap <= wrap_nxt;
        end
    end
endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: directed scenarios plus randomized traffic against a
// step-count reference model. Two instances cover DWELL=4 and DWELL=1.
module tb_decoder_scan;
    localparam int NO = 6;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en4 = 1'b0, mode4 = 1'b0;
    logic [2:0] sel4 = '0;
    logic [5:0] y4;
    logic [2:0] idx4;
    logic err4, wrap4;
    logic en1 = 1'b0, mode1 = 1'b0;
    logic [2:0] sel1 = '0;
    logic [5:0] y1;
    logic [2:0] idx1;
    logic err1, wrap1;

    int checks = 0;
    int failures = 0;

    // reference model state for the DWELL=4 instance
    int m_idx, m_cnt;
    logic [5:0] e_y;
    logic e_err, e_wrap;

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(3), .NUM_OUT(NO), .DWELL(DW)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .mode(mode4), .sel(sel4),
        .y(y4), .idx(idx4), .err(err4), .wrap(wrap4)
    );
    decoder_scan #(.SEL_W(3), .NUM_OUT(NO), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .mode(mode1), .sel(sel1),
        .y(y1), .idx(idx1), .err(err1), .wrap(wrap1)
    );

    task automatic model_reset();
        m_idx = 0; m_cnt = 0; e_y = '0; e_err = 1'b0; e_wrap = 1'b0;
    endtask

    // Behavioural step: scan position advances every DWELL enabled scan edges.
    task automatic model_edge();
        e_wrap = 1'b0;
        e_err  = 1'b0;
        e_y    = '0;
        if (en4) begin
            if (!mode4) begin
                m_cnt = 0;
                if (int'(sel4) < NO) begin
                    m_idx = int'(sel4);
                    e_y   = 6'(1 << m_idx);
                end else begin
                    e_err = 1'b1;
                end
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == DW) begin
                    m_cnt  = 0;
                    m_idx  = (m_idx + 1) % NO;
                    e_wrap = (m_idx == 0);
                end
                e_y = 6'(1 << m_idx);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en4 = 1'b1; mode4 = 1'b1; en1 = 1'b1; mode1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({y4, idx4, err4, wrap4} !== 11'b0) begin
            failures++;
            $display("FAIL reset_dut4 got y=%b idx=%0d err=%b wrap=%b want all zero", y4, idx4, err4, wrap4);
        end
        checks++;
        if ({y1, idx1, err1, wrap1} !== 11'b0) begin
            failures++;
            $display("FAIL reset_dut1 got y=%b idx=%0d err=%b wrap=%b want all zero", y1, idx1, err1, wrap1);
        end
        en4 = 1'b0; en1 = 1'b0; mode4 = 1'b0; mode1 = 1'b0;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_direct();
        en4 = 1'b1; mode4 = 1'b0;
        for (int s = 0; s < NO; s++) begin
            sel4 = 3'(s);
            tick();
            checks++;
            if ({y4, idx4, err4, wrap4} !== {6'(1 << s), 3'(s), 2'b00}) begin
                failures++;
                $display("FAIL direct sel=%0d got y=%b idx=%0d err=%b wrap=%b want y=%b idx=%0d err=0 wrap=0",
                         s, y4, idx4, err4, wrap4, 6'(1 << s), s);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] sv [3];
        sv[0] = 3'd6; sv[1] = 3'd7; sv[2] = 3'd2;
        en4 = 1'b1; mode4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel4 = sv[k];
            tick();
            checks++;
            if (k < 2) begin
                if ({y4, idx4, err4, wrap4} !== {6'b0, 3'd5, 2'b10}) begin
                    failures++;
                    $display("FAIL oor sel=%0d got y=%b idx=%0d err=%b want y=0 idx=5 err=1", sv[k], y4, idx4, err4);
                end
            end else if ({y4, idx4, err4, wrap4} !== {6'b000100, 3'd2, 2'b00}) begin
                failures++;
                $display("FAIL oor_recover got y=%b idx=%0d err=%b want y=000100 idx=2 err=0", y4, idx4, err4);
            end
        end
    endtask

    task automatic test_scan_wrap();
        int ei;
        en4 = 1'b0;
        do_reset();
        en4 = 1'b1; mode4 = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick();
            ei = (e / DW) % NO;
            checks++;
            if ({y4, idx4, err4, wrap4} !== {6'(1 << ei), 3'(ei), 1'b0, (e == 24)}) begin
                failures++;
                $display("FAIL scan edge=%0d got y=%b idx=%0d err=%b wrap=%b want y=%b idx=%0d wrap=%0d",
                         e, y4, idx4, err4, wrap4, 6'(1 << ei), ei, (e == 24));
            end
        end
    endtask

    task automatic test_freeze();
        en4 = 1'b0;
        do_reset();
        en4 = 1'b1; mode4 = 1'b1;
        repeat (9) tick();
        en4 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({y4, idx4, wrap4} !== {6'b0, 3'd2, 1'b0}) begin
                failures++;
                $display("FAIL freeze cyc=%0d got y=%b idx=%0d wrap=%b want y=0 idx=2", c, y4, idx4, wrap4);
            end
        end
        en4 = 1'b1;
        tick();
        checks++;
        if ({y4, idx4} !== {6'b000100, 3'd2}) begin
            failures++;
            $display("FAIL resume1 got y=%b idx=%0d want y=000100 idx=2", y4, idx4);
        end
        repeat (2) tick();
        checks++;
        if ({y4, idx4} !== {6'b001000, 3'd3}) begin
            failures++;
            $display("FAIL resume3 got y=%b idx=%0d want y=001000 idx=3", y4, idx4);
        end
    endtask

    task automatic test_async_reset();
        en4 = 1'b0;
        do_reset();
        en4 = 1'b1; mode4 = 1'b1;
        repeat (17) tick();
        checks++;
        if (idx4 !== 3'd4) begin
            failures++;
            $display("FAIL pre_async idx got %0d want 4", idx4);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({y4, idx4, err4, wrap4} !== 11'b0) begin
            failures++;
            $display("FAIL async_reset got y=%b idx=%0d want y=0 idx=0 before edge", y4, idx4);
        end
        model_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({y4, idx4} !== {6'b000001, 3'd0}) begin
            failures++;
            $display("FAIL restart3 got y=%b idx=%0d want y=000001 idx=0", y4, idx4);
        end
        tick();
        checks++;
        if ({y4, idx4} !== {6'b000010, 3'd1}) begin
            failures++;
            $display("FAIL restart4 got y=%b idx=%0d want y=000010 idx=1", y4, idx4);
        end
    endtask

    task automatic test_dwell1();
        en4 = 1'b0;
        do_reset();
        en1 = 1'b1; mode1 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if ({y1, idx1, wrap1} !== {6'(1 << e), 3'(e), 1'b0}) begin
                failures++;
                $display("FAIL dwell1 edge=%0d got y=%b idx=%0d wrap=%b want idx=%0d", e, y1, idx1, wrap1, e);
            end
        end
        mode1 = 1'b0; sel1 = 3'd5;
        tick();
        checks++;
        if ({y1, idx1, err1, wrap1} !== {6'b100000, 3'd5, 2'b00}) begin
            failures++;
            $display("FAIL dwell1_direct got y=%b idx=%0d want y=100000 idx=5", y1, idx1);
        end
        mode1 = 1'b1;
        tick();
        checks++;
        if ({y1, idx1, err1, wrap1} !== {6'b000001, 3'd0, 2'b01}) begin
            failures++;
            $display("FAIL dwell1_wrap got y=%b idx=%0d wrap=%b want y=000001 idx=0 wrap=1", y1, idx1, wrap1);
        end
        tick();
        checks++;
        if ({y1, idx1, wrap1} !== {6'b000010, 3'd1, 1'b0}) begin
            failures++;
            $display("FAIL dwell1_after got y=%b idx=%0d wrap=%b want y=000010 idx=1 wrap=0", y1, idx1, wrap1);
        end
        en1 = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            en4   = ($urandom_range(0, 9) < 8);
            mode4 = ($urandom_range(0, 3) != 0);
            sel4  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                checks++;
                if ({y4, idx4, err4, wrap4} !== 11'b0) begin
                    failures++;
                    $display("FAIL rand_reset cyc=%0d got y=%b idx=%0d", c, y4, idx4);
                end
            end
            tick();
            checks++;
            if ({y4, idx4, err4, wrap4} !== {e_y, 3'(m_idx), e_err, e_wrap} || $countones(y4) > 1) begin
                failures++;
                $display("FAIL random cyc=%0d got y=%b idx=%0d err=%b wrap=%b want y=%b idx=%0d err=%b wrap=%b",
                         c, y4, idx4, err4, wrap4, e_y, m_idx, e_err, e_wrap);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_direct();
        test_out_of_range();
        test_scan_wrap();
        test_freeze();
        test_async_reset();
        test_dwell1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
